// File: rtl/manchester_rcvr.sv
// -----------------------------------------------------------------------------
// manchester_rcvr
//
// Manchester (IEEE 802.3 polarity) serial receiver. It recovers bit timing from
// the mid-bit transitions of rxd, hunts through the preamble for the
// start-of-frame delimiter, then assembles payload bytes (LSB first) and
// presents each one as a single-cycle strobe.
//
// Parameters
//   CLK_FREQ   system clock frequency in Hz
//   BAUD       bit rate in Hz; CLK_FREQ/BAUD must be at least 4
//   SFD        start-of-frame delimiter byte
//
// Ports
//   clk         in   1  system clock, rising edge
//   rst         in   1  asynchronous, active-high reset
//   rxd         in   1  serial line, asynchronous to clk, idles high
//   data        out  8  last received payload byte, held until the next strobe
//   data_valid  out  1  one-cycle strobe per payload byte
//   cardet      out  1  carrier detect, high while a frame is in progress
//   eof         out  1  one-cycle strobe when the line goes idle after carrier
//   error       out  1  one-cycle strobe on a glitch or a partial final byte
// -----------------------------------------------------------------------------
module manchester_rcvr #(
  parameter int         CLK_FREQ = 100_000_000,
  parameter int         BAUD     = 25_000_000,
  parameter logic [7:0] SFD      = 8'hD0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rxd,
  output logic [7:0] data,
  output logic       data_valid,
  output logic       cardet,
  output logic       eof,
  output logic       error
);

  localparam int BIT_CLKS = CLK_FREQ / BAUD;
  localparam int MID_WIN  = (3 * BIT_CLKS) / 4;
  localparam int EOF_CLKS = (3 * BIT_CLKS) / 2;
  localparam int CNT_W    = $clog2(EOF_CLKS + 1);

  typedef logic [CNT_W-1:0] cnt_t;

  localparam cnt_t MID_WIN_C  = cnt_t'(MID_WIN);
  localparam cnt_t EOF_C      = cnt_t'(EOF_CLKS);
  localparam cnt_t EOF_M1_C   = cnt_t'(EOF_CLKS - 1);
  localparam cnt_t CNT_ONE_C  = cnt_t'(1);

  typedef enum logic [1:0] {
    QUIET = 2'd0,
    IDLE  = 2'd1,
    HUNT  = 2'd2,
    DATA  = 2'd3
  } state_t;

  // Synchronizer and edge-detector registers
  logic sync1_q;
  logic sync2_q;
  logic line_q;

  // Control and datapath registers
  state_t     state_q,  state_d;
  cnt_t       cnt_q,    cnt_d;
  logic       first_q,  first_d;
  logic       bnd_q,    bnd_d;
  logic [7:0] win_q,    win_d;
  logic [7:0] shift_q,  shift_d;
  logic [2:0] bitcnt_q, bitcnt_d;
  logic [7:0] data_q,   data_d;
  logic       dv_q,     dv_d;
  logic       cardet_q, cardet_d;
  logic       eof_q,    eof_d;
  logic       err_q,    err_d;

  // Combinational helpers
  logic       edge_w;
  logic       fall_w;
  logic       mid_ok_w;
  cnt_t       cnt_inc_w;
  logic [7:0] win_shift_w;
  logic [7:0] byte_shift_w;

  // ---------------------------------------------------------------------------
  // Stage 0/1: two-flop synchronizer. Preset high so that releasing reset on an
  // idle line never looks like a falling edge.
  // Stage 2: registered copy of the synchronized line for edge detection.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      line_q  <= 1'b1;
    end else begin
      sync1_q <= rxd;
      sync2_q <= sync1_q;
      line_q  <= sync2_q;
    end
  end

  // An edge is a difference between the newest synchronized sample and the
  // previous one; the newest sample is also the decoded bit value, because the
  // mid-bit transition of a 1 is rising and of a 0 is falling.
  assign edge_w = sync2_q ^ line_q;
  assign fall_w = line_q & ~sync2_q;

  // The first edge after carrier pickup has no timing reference, so it is taken
  // as mid-bit whatever the timer says.
  assign mid_ok_w = edge_w & (first_q | (cnt_q >= MID_WIN_C));

  // The timer saturates so it cannot wrap back into the mid-bit window.
  assign cnt_inc_w = (cnt_q == EOF_C) ? cnt_q : cnt_q + CNT_ONE_C;

  assign win_shift_w  = {sync2_q, win_q[7:1]};
  assign byte_shift_w = {sync2_q, shift_q[7:1]};

  // ---------------------------------------------------------------------------
  // Stage 3: FSM state and output registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= QUIET;
      cnt_q    <= '0;
      first_q  <= 1'b0;
      bnd_q    <= 1'b0;
      win_q    <= '0;
      shift_q  <= '0;
      bitcnt_q <= '0;
      data_q   <= '0;
      dv_q     <= 1'b0;
      cardet_q <= 1'b0;
      eof_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      first_q  <= first_d;
      bnd_q    <= bnd_d;
      win_q    <= win_d;
      shift_q  <= shift_d;
      bitcnt_q <= bitcnt_d;
      data_q   <= data_d;
      dv_q     <= dv_d;
      cardet_q <= cardet_d;
      eof_q    <= eof_d;
      err_q    <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_inc_w;
    first_d  = first_q;
    bnd_d    = bnd_q;
    win_d    = win_q;
    shift_d  = shift_q;
    bitcnt_d = bitcnt_q;
    data_d   = data_q;
    dv_d     = 1'b0;
    cardet_d = cardet_q;
    eof_d    = 1'b0;
    err_d    = 1'b0;

    case (state_q)
      // Wait for the line to sit high long enough that we are not re-arming in
      // the middle of someone else's frame. Any low sample restarts the count.
      QUIET: begin
        cardet_d = 1'b0;
        if (!line_q) begin
          cnt_d = '0;
        end else if (cnt_q >= EOF_M1_C) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_ONE_C;
        end
      end

      // The falling edge out of idle is the leading bit boundary of the first
      // preamble bit (a 1 starts low).
      IDLE: begin
        cnt_d = '0;
        if (fall_w) begin
          state_d  = HUNT;
          cardet_d = 1'b1;
          cnt_d    = CNT_ONE_C;
          first_d  = 1'b1;
          bnd_d    = 1'b0;
          win_d    = '0;
        end
      end

      HUNT, DATA: begin
        if (edge_w) begin
          if (mid_ok_w) begin
            cnt_d   = CNT_ONE_C;
            first_d = 1'b0;
            bnd_d   = 1'b0;
            if (state_q == HUNT) begin
              win_d = win_shift_w;
              if (win_shift_w == SFD) begin
                state_d  = DATA;
                bitcnt_d = '0;
              end
            end else begin
              shift_d  = byte_shift_w;
              bitcnt_d = bitcnt_q + 3'd1;
              if (bitcnt_q == 3'd7) begin
                data_d = byte_shift_w;
                dv_d   = 1'b1;
              end
            end
          end else if (bnd_q) begin
            // Two early edges within one bit cannot be valid Manchester.
            err_d    = 1'b1;
            cardet_d = 1'b0;
            cnt_d    = '0;
            state_d  = QUIET;
          end else begin
            // Bit-boundary edge between equal bits: note it, keep timing from
            // the last mid-bit edge.
            bnd_d = 1'b1;
          end
        end else if (cnt_q == EOF_C) begin
          eof_d    = 1'b1;
          cardet_d = 1'b0;
          state_d  = IDLE;
          if ((state_q == DATA) && (bitcnt_q != 3'd0)) begin
            err_d = 1'b1;
          end
        end
      end

      default: begin
        state_d = QUIET;
      end
    endcase
  end

  assign data       = data_q;
  assign data_valid = dv_q;
  assign cardet     = cardet_q;
  assign eof        = eof_q;
  assign error      = err_q;

endmodule
